// File: rtl/nav_pkg.sv
// Shared types and constants for the navigation integrator: FSM states,
// command opcodes, one-hot velocity modes and their divisors.
package nav_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CRUISE   = 2'd1,
        ST_COOLDOWN = 2'd2
    } nav_state_t;

    typedef enum logic [1:0] {
        OP_RESET_POS = 2'd0,
        OP_CRUISE    = 2'd1,
        OP_JUMP      = 2'd2,
        OP_HOLD      = 2'd3
    } nav_op_t;

    localparam logic [3:0] MODE_STOP    = 4'b0001;
    localparam logic [3:0] MODE_ATTACK  = 4'b0010;
    localparam logic [3:0] MODE_DEFENSE = 4'b0100;
    localparam logic [3:0] MODE_STEALTH = 4'b1000;

    localparam int DIV_STEALTH = 3;
    localparam int DIV_DEFENSE = 2;
    localparam int DIV_ATTACK  = 1;

endpackage

// File: rtl/nav_axis.sv
// One axis of the integrator: mode-scaled velocity, adder and position register.
// NAV_SATURATE_EN selects clamping (with a clamp pulse) instead of wraparound.
module nav_axis
    import nav_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          mode,
    input  logic signed [W-1:0] speed,
    input  logic signed [W-1:0] jump_val,
    input  logic                integrate,
    input  logic                load_zero,
    input  logic                load_jump,
    output logic signed [W-1:0] pos,
    output logic                clamp
);

    localparam logic signed [W-1:0] D_STEALTH = W'(DIV_STEALTH);
    localparam logic signed [W-1:0] D_DEFENSE = W'(DIV_DEFENSE);
    localparam logic signed [W-1:0] D_ATTACK  = W'(DIV_ATTACK);

    logic signed [W-1:0] vel;
    logic signed [W-1:0] pos_next;

    // Signed division truncates toward zero; anything not exactly one-hot stops.
    always_comb begin
        vel = '0;
        case (mode)
            MODE_STEALTH: vel = speed / D_STEALTH;
            MODE_DEFENSE: vel = speed / D_DEFENSE;
            MODE_ATTACK:  vel = speed / D_ATTACK;
            default:      vel = '0;
        endcase
    end

`ifdef NAV_SATURATE_EN
    function automatic logic signed [W-1:0] saturate(input logic signed [W:0] s);
        if (s[W] != s[W-1])
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return s[W-1:0];
    endfunction

    logic signed [W:0] sum;
    assign sum      = {pos[W-1], pos} + {vel[W-1], vel};
    assign pos_next = saturate(sum);
    assign clamp    = integrate && (sum[W] != sum[W-1]);
`else
    function automatic logic signed [W-1:0] wrap_add(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
        return a + b;
    endfunction

    assign pos_next = wrap_add(pos, vel);
    assign clamp    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pos <= '0;
        else if (load_zero)
            pos <= '0;
        else if (load_jump)
            pos <= jump_val;
        else if (integrate)
            pos <= pos_next;
    end

endmodule

// File: rtl/nav_integrator.sv
// N-axis position integrator with valid/ready command port and post-jump cooldown.
// NAV_SATURATE_EN enables per-axis clamping and the sticky overflow flag.
module nav_integrator
    import nav_pkg::*;
#(
    parameter int W        = 16,
    parameter int AXES     = 3,
    parameter int COOLDOWN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          mode,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [AXES*W-1:0]   jump_pos,
    input  logic [AXES*W-1:0]   speed,
    output logic [AXES*W-1:0]   pos,
    output logic [1:0]          state,
    output logic                busy,
    output logic                overflow
);

    localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    nav_state_t       st;
    nav_op_t          op;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             integrate;
    logic             load_zero;
    logic             load_jump;
    logic [AXES-1:0]  clamp;

    assign op        = nav_op_t'(cmd_op);
    assign cmd_ready = (st != ST_COOLDOWN);
    assign accept    = cmd_valid && cmd_ready;
    // An accepted command always pre-empts that edge's integration step.
    assign integrate = (st == ST_CRUISE) && !accept;
    assign load_zero = accept && (op == OP_RESET_POS);
    assign load_jump = accept && (op == OP_JUMP);
    assign state     = st;

    for (genvar a = 0; a < AXES; a++) begin : g_axis
        nav_axis #(.W(W)) u_axis (
            .clk       (clk),
            .rst       (rst),
            .mode      (mode),
            .speed     (speed[a*W +: W]),
            .jump_val  (jump_pos[a*W +: W]),
            .integrate (integrate),
            .load_zero (load_zero),
            .load_jump (load_jump),
            .pos       (pos[a*W +: W]),
            .clamp     (clamp[a])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (load_zero)
                overflow <= 1'b0;
            else if (|clamp)
                overflow <= 1'b1;

            case (st)
                ST_COOLDOWN: begin
                    if (cnt == '0) begin
                        st   <= ST_IDLE;
                        busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        case (op)
                            OP_CRUISE: st <= ST_CRUISE;
                            OP_JUMP: begin
                                st   <= ST_COOLDOWN;
                                busy <= 1'b1;
                                cnt  <= CNT_W'(COOLDOWN - 1);
                            end
                            default:   st <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nav_integrator.sv
// Scoreboard bench for nav_integrator: a behavioural model pushes expected
// outputs per edge; each scenario task pops and compares after the edge.
module tb_nav_integrator;
    import nav_pkg::*;

    localparam int W        = 16;
    localparam int AXES     = 3;
    localparam int COOLDOWN = 8;
    localparam int PMAX     = 2**(W-1) - 1;
    localparam int NMIN     = -(2**(W-1));

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        mode = MODE_STOP;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [AXES*W-1:0] jump_pos = '0;
    logic [AXES*W-1:0] speed = '0;
    logic [AXES*W-1:0] pos;
    logic [1:0]        state;
    logic              busy;
    logic              overflow;

    always #5 clk = ~clk;

    nav_integrator #(.W(W), .AXES(AXES), .COOLDOWN(COOLDOWN)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .jump_pos  (jump_pos),
        .speed     (speed),
        .pos       (pos),
        .state     (state),
        .busy      (busy),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic [AXES*W-1:0] p;
        logic [1:0]        st;
        logic              rdy;
        logic              bsy;
        logic              ovf;
    } obs_t;

    obs_t exp_q[$];
    obs_t e, a;
    int   checks = 0;
    int   passed = 0;

    int sp[AXES];
    int jp[AXES];
    int m_pos[AXES];
    int m_state = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;

    function automatic obs_t observe();
        obs_t o;
        o.p   = pos;
        o.st  = state;
        o.rdy = cmd_ready;
        o.bsy = busy;
        o.ovf = overflow;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        for (int i = 0; i < AXES; i++) o.p[i*W +: W] = W'(m_pos[i]);
        o.st  = 2'(m_state);
        o.rdy = (m_state != 2);
        o.bsy = (m_state == 2);
        o.ovf = m_ovf;
        return o;
    endfunction

    function automatic int vel_of(int s, logic [3:0] md);
        case (md)
            4'b1000: return s / 3;
            4'b0100: return s / 2;
            4'b0010: return s;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < AXES; i++) m_pos[i] = 0;
        m_state = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, advance one edge.
    task automatic step(input bit valid, input logic [1:0] op);
        int np[AXES];
        int ns, nc, v;
        bit novf, acc;
        cmd_valid = valid;
        cmd_op    = op;
        for (int i = 0; i < AXES; i++) begin
            speed[i*W +: W]    = W'(sp[i]);
            jump_pos[i*W +: W] = W'(jp[i]);
        end
        np = m_pos; ns = m_state; nc = m_cnt; novf = m_ovf;
        acc = valid && (m_state != 2);
        if (acc) begin
            case (op)
                2'd0: begin for (int i = 0; i < AXES; i++) np[i] = 0; novf = 1'b0; ns = 0; end
                2'd1: ns = 1;
                2'd2: begin np = jp; nc = COOLDOWN - 1; ns = 2; end
                default: ns = 0;
            endcase
        end else if (m_state == 1) begin
            for (int i = 0; i < AXES; i++) begin
                v = m_pos[i] + vel_of(sp[i], mode);
`ifdef NAV_SATURATE_EN
                if (v > PMAX) begin v = PMAX; novf = 1'b1; end
                else if (v < NMIN) begin v = NMIN; novf = 1'b1; end
`else
                v = ((v - NMIN) & (2**W - 1)) + NMIN;
`endif
                np[i] = v;
            end
        end else if (m_state == 2) begin
            if (m_cnt == 0) ns = 0;
            else nc = m_cnt - 1;
        end
        m_pos = np; m_state = ns; m_cnt = nc; m_ovf = novf;
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (observe() !== obs_t'{p: '0, st: 2'd0, rdy: 1'b1, bsy: 1'b0, ovf: 1'b0})
            $display("FAIL reset_values: got (pos,st,rdy,busy,ovf)=%h want %h", observe(),
                     obs_t'{p: '0, st: 2'd0, rdy: 1'b1, bsy: 1'b0, ovf: 1'b0});
        else passed++;
        step(1'b0, OP_HOLD);
        e = exp_q.pop_front(); a = observe(); checks++;
        if (a !== e) $display("FAIL reset_idle: got %h want %h", a, e); else passed++;
    endtask

    task automatic test_cruise_attack();
        mode = MODE_ATTACK;
        for (int i = 0; i < AXES; i++) sp[i] = 1;
        step(1'b1, OP_RESET_POS);
        e = exp_q.pop_front(); a = observe(); checks++;
        if (a !== e) $display("FAIL attack_resetpos: got %h want %h", a, e); else passed++;
        step(1'b1, OP_CRUISE);
        e = exp_q.pop_front(); a = observe(); checks++;
        if (a !== e) $display("FAIL attack_accept: got %h want %h", a, e); else passed++;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, OP_HOLD);
            e = exp_q.pop_front(); a = observe(); checks++;
            if (a !== e) $display("FAIL attack_step%0d: got %h want %h", k, a, e); else passed++;
        end
        checks++;
        if (pos !== {16'sd5, 16'sd5, 16'sd5})
            $display("FAIL attack_pos555: got %h want %h", pos, {16'sd5, 16'sd5, 16'sd5});
        else passed++;
    endtask

    task automatic test_cruise_stealth();
        mode = MODE_STEALTH;
        sp[0] = 9; sp[1] = -7; sp[2] = 2;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, OP_HOLD);
            e = exp_q.pop_front(); a = observe(); checks++;
            if (a !== e) $display("FAIL stealth_step%0d: got %h want %h", k, a, e); else passed++;
        end
        checks++;
        if (pos !== {16'sd5, 16'sd1, 16'sd11})
            $display("FAIL stealth_pos: got %h want %h", pos, {16'sd5, 16'sd1, 16'sd11});
        else passed++;
    endtask

    task automatic test_mode_edges();
        logic [3:0] modes [4] = '{4'b0110, 4'b0000, MODE_DEFENSE, MODE_STOP};
        sp[0] = -5; sp[1] = 7; sp[2] = -1;
        for (int k = 0; k < 4; k++) begin
            mode = modes[k];
            step(1'b0, OP_HOLD);
            e = exp_q.pop_front(); a = observe(); checks++;
            if (a !== e) $display("FAIL mode_%b: got %h want %h", modes[k], a, e); else passed++;
        end
    endtask

    task automatic test_jump_cooldown();
        mode = MODE_ATTACK;
        for (int i = 0; i < AXES; i++) begin sp[i] = 4; jp[i] = 100; end
        step(1'b1, OP_JUMP);
        e = exp_q.pop_front(); a = observe(); checks++;
        if (a !== e) $display("FAIL jump_accept: got %h want %h", a, e); else passed++;
        checks++;
        if (pos !== {16'sd100, 16'sd100, 16'sd100} || cmd_ready !== 1'b0)
            $display("FAIL jump_pos100: got pos=%h rdy=%b want pos=%h rdy=0", pos, cmd_ready,
                     {16'sd100, 16'sd100, 16'sd100});
        else passed++;
        for (int k = 0; k < COOLDOWN; k++) begin
            step(1'b1, OP_CRUISE);
            e = exp_q.pop_front(); a = observe(); checks++;
            if (a !== e) $display("FAIL cooldown_edge%0d: got %h want %h", k + 1, a, e); else passed++;
        end
        checks++;
        if (pos !== {16'sd100, 16'sd100, 16'sd100} || cmd_ready !== 1'b1 || state !== 2'd0)
            $display("FAIL cooldown_exit: got pos=%h rdy=%b st=%0d want pos=100s rdy=1 st=0",
                     pos, cmd_ready, state);
        else passed++;
        step(1'b1, OP_CRUISE);
        e = exp_q.pop_front(); a = observe(); checks++;
        if (a !== e) $display("FAIL post_cool_accept: got %h want %h", a, e); else passed++;
        step(1'b0, OP_HOLD);
        e = exp_q.pop_front(); a = observe(); checks++;
        if (a !== e) $display("FAIL post_cool_add: got %h want %h", a, e); else passed++;
        checks++;
        if (pos !== {16'sd104, 16'sd104, 16'sd104})
            $display("FAIL pos104: got %h want %h", pos, {16'sd104, 16'sd104, 16'sd104});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [5] = '{OP_HOLD, OP_CRUISE, OP_CRUISE, OP_HOLD, OP_RESET_POS};
        mode = MODE_ATTACK;
        for (int i = 0; i < AXES; i++) sp[i] = 3;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, ops[k]);
            e = exp_q.pop_front(); a = observe(); checks++;
            if (a !== e) $display("FAIL b2b_cmd%0d: got %h want %h", k, a, e); else passed++;
        end
    endtask

    task automatic test_saturate();
        mode = MODE_ATTACK;
        for (int i = 0; i < AXES; i++) begin sp[i] = 4; jp[i] = 32765; end
        step(1'b1, OP_JUMP);
        repeat (COOLDOWN) step(1'b0, OP_HOLD);
        step(1'b1, OP_CRUISE);
        step(1'b0, OP_HOLD);
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        e = exp_q.pop_front(); a = observe(); checks++;
        if (a !== e) $display("FAIL sat_edge: got %h want %h", a, e); else passed++;
        checks++;
`ifdef NAV_SATURATE_EN
        if (pos !== {3{16'sh7FFF}} || overflow !== 1'b1)
            $display("FAIL sat_clamp: got pos=%h ovf=%b want pos=%h ovf=1", pos, overflow, {3{16'sh7FFF}});
`else
        if (pos !== {3{16'sh8001}} || overflow !== 1'b0)
            $display("FAIL sat_wrap: got pos=%h ovf=%b want pos=%h ovf=0", pos, overflow, {3{16'sh8001}});
`endif
        else passed++;
        step(1'b0, OP_HOLD);
        e = exp_q.pop_front(); a = observe(); checks++;
        if (a !== e) $display("FAIL sat_sticky: got %h want %h", a, e); else passed++;
        step(1'b1, OP_RESET_POS);
        e = exp_q.pop_front(); a = observe(); checks++;
        if (a !== e) $display("FAIL sat_clear: got %h want %h", a, e); else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < AXES; i++) jp[i] = 100;
        step(1'b1, OP_JUMP);
        step(1'b0, OP_HOLD);
        step(1'b0, OP_HOLD);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = observe();
        end
        checks++;
        if (a !== e) $display("FAIL async_pre: got %h want %h", a, e); else passed++;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (observe() !== model_obs())
            $display("FAIL async_reset: got %h want %h", observe(), model_obs());
        else passed++;
        #1;
        rst = 1'b0;
        step(1'b0, OP_HOLD);
        e = exp_q.pop_front(); a = observe(); checks++;
        if (a !== e) $display("FAIL async_release: got %h want %h", a, e); else passed++;
        step(1'b1, OP_CRUISE);
        e = exp_q.pop_front(); a = observe(); checks++;
        if (a !== e) $display("FAIL async_accept: got %h want %h", a, e); else passed++;
    endtask

    initial begin
        for (int i = 0; i < AXES; i++) begin sp[i] = 0; jp[i] = 0; m_pos[i] = 0; end
        test_reset();
        test_cruise_attack();
        test_cruise_stealth();
        test_mode_edges();
        test_jump_cooldown();
        test_back_to_back();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
